// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity selectors shared by the UART receive and transmit paths.
// No ports. Optional receive feature macro: UART_RX_MAJORITY_EN (used by uart_rx_sampler).
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and bit-value decision for uart_rx.
// Ports: clk, rst (async, active-high), rx_in (serial line), restart (hold edge_cnt at 0),
//        sample_bit (decided bit value), sample_stb (1 cycle at the decision point),
//        bit_end (edge_cnt == PRESCALE-1).
// Macro UART_RX_MAJORITY_EN: 2-of-3 vote over edge_cnt SP-1, SP, SP+1, decided at SP+1;
// otherwise a single sample at SP.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic restart,
  output logic sample_bit,
  output logic sample_stb,
  output logic bit_end
);
  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] SP   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
  logic [EW-1:0] edge_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) edge_cnt <= '0;
    else edge_cnt <= (restart || edge_cnt == LAST) ? '0 : edge_cnt + 1'b1;
  assign bit_end = edge_cnt == LAST;
`ifdef UART_RX_MAJORITY_EN
  // win[1] holds the SP-1 sample and win[0] the SP sample; the live line is the third vote.
  logic [1:0] win;
  always_ff @(posedge clk or posedge rst)
    if (rst) win <= '0;
    else if (edge_cnt == SP - 1'b1 || edge_cnt == SP) win <= {win[0], rx_in};
  assign sample_bit = (win[1] & win[0]) | (win[1] & rx_in) | (win[0] & rx_in);
  assign sample_stb = edge_cnt == SP + 1'b1;
`else
  assign sample_bit = rx_in;
  assign sample_stb = edge_cnt == SP;
`endif
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8E1/8O1 UART receiver with PRESCALE-times oversampling.
// Ports: clk, rst (async, active-high), rx_in (serial, idle high), par_en, par_typ (0 even / 1 odd),
//        p_data (last good byte), data_valid / par_err / stp_err (1-cycle pulses), busy (not IDLE).
// Macro UART_RX_MAJORITY_EN (see uart_rx_sampler) moves every sample-point action to SP+1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_typ,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bad, pen, ptyp;
  logic              sample_bit, sample_stb, bit_end;
  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .restart    (state == IDLE),
    .sample_bit (sample_bit),
    .sample_stb (sample_stb),
    .bit_end    (bit_end)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state)
        IDLE: if (!rx_in) begin
          state   <= START;
          busy    <= 1'b1;
          pen     <= par_en;
          ptyp    <= par_typ;
          par_bad <= 1'b0;
        end
        START: if (sample_stb && sample_bit) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (bit_end) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: begin
          if (sample_stb) shreg[bit_cnt] <= sample_bit;
          if (bit_end) begin
            if (bit_cnt == CW'(DATA_W - 1)) state <= pen ? PARITY : STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (sample_stb) par_bad <= sample_bit != ((ptyp == PAR_ODD) ? ~^shreg : ^shreg);
          if (bit_end) state <= STOP;
        end
        STOP: if (sample_stb) begin
          // Leave half a bit early so a back-to-back start edge is caught from IDLE.
          state   <= IDLE;
          busy    <= 1'b0;
          stp_err <= !sample_bit;
          par_err <= par_bad;
          if (sample_bit && !par_bad) begin
            p_data     <= shreg;
            data_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule
